distri_ram_mp: RTL and testbench

Multi-read-port distributed RAM for the Aquila core, for register-file-style and small-table storage needing more than one asynchronous read per cycle. One synchronous write port with byte enables, NRD asynchronous read ports, optional same-cycle write-to-read bypass, and a hardware clear sequencer. The clear sequencer sweeps every entry to INIT_VALUE after reset or on request, so contents never depend on simulation-only initialisation.

---
 rtl/distri_ram_pkg.sv | 31 +++
 rtl/distri_ram_clr_seq.sv | 69 ++++++
 rtl/distri_ram_mp.sv | 106 ++++++++++
 tb/tb_distri_ram_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/distri_ram_pkg.sv
// Shared definitions for the distri_ram family: clear-sequencer state encoding
// and the byte-merge helper used by both the write path and the bypass path.
package distri_ram_pkg;

   localparam int MAX_XLEN  = 128;
   localparam int MAX_BYTES = MAX_XLEN / 8;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_state_e;

   // Operands are zero-extended to MAX_XLEN so one function serves every XLEN.
   function automatic logic [MAX_XLEN-1:0] byte_merge(
      input logic [MAX_XLEN-1:0]  old_w,
      input logic [MAX_XLEN-1:0]  new_w,
      input logic [MAX_BYTES-1:0] be
   );
      logic [MAX_XLEN-1:0] merged;
      merged = old_w;
      for (int k = 0; k < MAX_BYTES; k++) begin
         if (be[k]) begin
            merged[8*k +: 8] = new_w[8*k +: 8];
         end else begin
            merged[8*k +: 8] = old_w[8*k +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/distri_ram_clr_seq.sv
// Clear sequencer: sweeps a pointer over every entry after reset or on request
// and reports busy while the sweep is in progress.
module distri_ram_clr_seq
   import distri_ram_pkg::*;
#(
   parameter int ENTRY_NUM = 32,
   parameter int AWDTH     = $clog2(ENTRY_NUM)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   output logic             clr_we,
   output logic [AWDTH-1:0] clr_addr,
   output logic             busy
);

   localparam logic [AWDTH-1:0] LAST_PTR = AWDTH'(ENTRY_NUM - 1);

   ram_state_e       state_r;
   ram_state_e       state_s;
   logic [AWDTH-1:0] ptr_r;
   logic [AWDTH-1:0] ptr_s;

   // Next-state and pointer decode.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      case (state_r)
         CLEAR: begin
            if (ptr_r == LAST_PTR) begin
               state_s = READY;
               ptr_s   = '0;
            end else begin
               state_s = CLEAR;
               ptr_s   = ptr_r + AWDTH'(1);
            end
         end
         READY: begin
            if (clear_i) begin
               state_s = CLEAR;
               ptr_s   = '0;
            end else begin
               state_s = READY;
               ptr_s   = ptr_r;
            end
         end
         default: begin
            state_s = CLEAR;
            ptr_s   = '0;
         end
      endcase
   end

   // State and pointer registers; reset holds the sweep at entry 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= CLEAR;
         ptr_r   <= '0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
      end
   end

   assign clr_we   = (state_r == CLEAR) && !rst_i;
   assign clr_addr = ptr_r;
   assign busy     = (state_r == CLEAR);

endmodule

// File: rtl/distri_ram_mp.sv
// Multi-read-port distributed RAM: one byte-enabled synchronous write port,
// NRD combinational read ports, optional write-to-read bypass, hardware clear.
module distri_ram_mp
   import distri_ram_pkg::*;
#(
   parameter int               ENTRY_NUM  = 32,
   parameter int               XLEN       = 32,
   parameter int               NRD        = 2,
   parameter int               BYPASS     = 1,
   parameter logic [XLEN-1:0]  INIT_VALUE = '0,
   parameter int               AWDTH      = $clog2(ENTRY_NUM)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [XLEN/8-1:0]     be_i,
   input  logic [AWDTH-1:0]      write_addr_i,
   input  logic [XLEN-1:0]       data_i,
   input  logic [NRD*AWDTH-1:0]  read_addr_i,
   output logic [NRD*XLEN-1:0]   data_o,
   input  logic                  clear_i,
   output logic                  busy_o
);

   localparam int                NBYTES    = XLEN / 8;
   localparam logic [AWDTH:0]    DEPTH_LIM = (AWDTH + 1)'(ENTRY_NUM);

   logic             clr_we_s;
   logic [AWDTH-1:0] clr_addr_s;
   logic             busy_s;
   logic             wr_en_s;
   logic [XLEN-1:0]  wr_merged_s;
   logic [XLEN-1:0]  mem_r [ENTRY_NUM];

   function automatic logic [XLEN-1:0] merge_word(
      input logic [XLEN-1:0]   old_w,
      input logic [XLEN-1:0]   new_w,
      input logic [NBYTES-1:0] be
   );
      logic [MAX_XLEN-1:0]  old_x;
      logic [MAX_XLEN-1:0]  new_x;
      logic [MAX_XLEN-1:0]  res_x;
      logic [MAX_BYTES-1:0] be_x;
      old_x = '0;
      new_x = '0;
      be_x  = '0;
      old_x[XLEN-1:0]   = old_w;
      new_x[XLEN-1:0]   = new_w;
      be_x[NBYTES-1:0]  = be;
      res_x = byte_merge(old_x, new_x, be_x);
      return res_x[XLEN-1:0];
   endfunction

   function automatic logic addr_ok(input logic [AWDTH-1:0] a);
      return ({1'b0, a} < DEPTH_LIM);
   endfunction

   distri_ram_clr_seq #(
      .ENTRY_NUM (ENTRY_NUM),
      .AWDTH     (AWDTH)
   ) u_clr_seq (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s),
      .busy     (busy_s)
   );

   // A user write is dropped during a sweep, under reset, or when clear_i wins.
   assign wr_en_s     = we_i && !busy_s && !rst_i && !clear_i && addr_ok(write_addr_i);
   assign wr_merged_s = merge_word(mem_r[write_addr_i], data_i, be_i);

   // Storage update; left unreset so it maps onto LUTRAM.
   always_ff @(posedge clk_i) begin
      if (clr_we_s) begin
         mem_r[clr_addr_s] <= INIT_VALUE;
      end else if (wr_en_s) begin
         mem_r[write_addr_i] <= wr_merged_s;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AWDTH-1:0] ra_s;
      logic [XLEN-1:0]  rd_s;

      assign ra_s = read_addr_i[p*AWDTH +: AWDTH];

      // Read mux: INIT during a sweep or out of range, else bypass or stored.
      always_comb begin
         rd_s = INIT_VALUE;
         if (busy_s || !addr_ok(ra_s)) begin
            rd_s = INIT_VALUE;
         end else if ((BYPASS != 0) && wr_en_s && (ra_s == write_addr_i)) begin
            rd_s = wr_merged_s;
         end else begin
            rd_s = mem_r[ra_s];
         end
      end

      assign data_o[p*XLEN +: XLEN] = rd_s;
   end

   assign busy_o = busy_s;

endmodule

// File: tb/tb_distri_ram_mp.sv
// Scoreboard bench: dut0 (NRD=4, bypass on) and dut1 (NRD=2, bypass off)
// share all stimulus; a negedge monitor pops expectations and compares.
module tb_distri_ram_mp;

   localparam int AW = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           we;
   logic [3:0]     be;
   logic [AW-1:0]  waddr;
   logic [31:0]    wdata;
   logic           clr;
   logic [4*AW-1:0] raddr0;
   logic [2*AW-1:0] raddr1;
   logic [4*32-1:0] rdata0;
   logic [2*32-1:0] rdata1;
   logic            busy0;
   logic            busy1;

   typedef struct {
      int          dut;
      int          lane;
      logic [31:0] exp;
      string       nm;
   } sb_t;

   sb_t sb_q[$];
   int  n_cmp = 0;
   int  n_mis = 0;

   always #5 clk = ~clk;

   distri_ram_mp #(
      .ENTRY_NUM (32), .XLEN (32), .NRD (4), .BYPASS (1), .INIT_VALUE (32'h0)
   ) dut0 (
      .clk_i (clk), .rst_i (rst), .we_i (we), .be_i (be),
      .write_addr_i (waddr), .data_i (wdata), .read_addr_i (raddr0),
      .data_o (rdata0), .clear_i (clr), .busy_o (busy0)
   );

   distri_ram_mp #(
      .ENTRY_NUM (32), .XLEN (32), .NRD (2), .BYPASS (0), .INIT_VALUE (32'h0)
   ) dut1 (
      .clk_i (clk), .rst_i (rst), .we_i (we), .be_i (be),
      .write_addr_i (waddr), .data_i (wdata), .read_addr_i (raddr1),
      .data_o (rdata1), .clear_i (clr), .busy_o (busy1)
   );

   // Monitor: compare every pending expectation against the settled outputs.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         sb_t         e;
         logic [31:0] act;
         e = sb_q.pop_front();
         if (e.lane < 0)
            act = (e.dut == 0) ? {31'd0, busy0} : {31'd0, busy1};
         else
            act = (e.dut == 0) ? rdata0[e.lane*32 +: 32] : rdata1[e.lane*32 +: 32];
         n_cmp++;
         if (act !== e.exp) begin
            n_mis++;
            $display("FAIL %s dut%0d lane%0d: got %h want %h", e.nm, e.dut, e.lane, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_lane(input int d, input int l, input logic [31:0] v, input string nm);
      sb_t e;
      e.dut = d; e.lane = l; e.exp = v; e.nm = nm;
      sb_q.push_back(e);
   endtask

   task automatic exp_busy(input logic b, input string nm);
      exp_lane(0, -1, {31'd0, b}, nm);
      exp_lane(1, -1, {31'd0, b}, nm);
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
      raddr0 = {a3, a2, a1, a0};
      raddr1 = {a1, a0};
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
      we = 1'b1; waddr = a; wdata = d; be = b;
      tick();
      we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; we = 1'b0; be = 4'h0; waddr = 5'd0; wdata = 32'h0; clr = 1'b0;
      set_rd(5'd0, 5'd1, 5'd2, 5'd3);

      // reset state
      repeat (3) tick();
      exp_busy(1'b1, "reset_busy");
      exp_lane(0, 0, 32'h0, "reset_data");
      exp_lane(1, 1, 32'h0, "reset_data");
      rst = 1'b0;

      // initial sweep: write to addr 5 and a clear_i pulse must both be ignored
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (i == 3) begin we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; be = 4'hF; end
         if (i == 4) we = 1'b0;
         if (i == 6) clr = 1'b1;
         if (i == 7) clr = 1'b0;
         exp_busy(i < 32, "sweep_busy");
         if (i < 32) exp_lane(0, 0, 32'h0, "sweep_data");
      end

      // every entry reads INIT after the sweep (including addr 5)
      for (int j = 0; j < 32; j += 4) begin
         set_rd(5'(j), 5'(j + 1), 5'(j + 2), 5'(j + 3));
         for (int l = 0; l < 4; l++) exp_lane(0, l, 32'h0, "post_sweep_init");
         tick();
      end

      // byte enables
      wr(5'd7, 32'h11223344, 4'hF);
      wr(5'd7, 32'hAABBCCDD, 4'b0101);
      set_rd(5'd7, 5'd7, 5'd0, 5'd0);
      exp_lane(0, 0, 32'h11BB33DD, "byte_en");
      exp_lane(0, 1, 32'h11BB33DD, "byte_en_dup");
      exp_lane(1, 0, 32'h11BB33DD, "byte_en");
      tick();

      // bypass vs no bypass, same cycle and next cycle
      we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; be = 4'b0011;
      set_rd(5'd3, 5'd3, 5'd0, 5'd0);
      exp_lane(0, 0, 32'h00005678, "bypass_p0");
      exp_lane(0, 1, 32'h00005678, "bypass_p1");
      exp_lane(1, 0, 32'h00000000, "nobypass_p0");
      exp_lane(1, 1, 32'h00000000, "nobypass_p1");
      tick();
      we = 1'b0;
      exp_lane(0, 0, 32'h00005678, "after_write_p0");
      exp_lane(1, 0, 32'h00005678, "nobypass_next_p0");
      exp_lane(1, 1, 32'h00005678, "nobypass_next_p1");
      tick();

      // four distinct ports in one cycle
      wr(5'd0,  32'hA0A0A0A0, 4'hF);
      wr(5'd1,  32'hB1B1B1B1, 4'hF);
      wr(5'd30, 32'hC3C3C3C3, 4'hF);
      wr(5'd31, 32'hD4D4D4D4, 4'hF);
      set_rd(5'd0, 5'd1, 5'd30, 5'd31);
      exp_lane(0, 0, 32'hA0A0A0A0, "mp_lane0");
      exp_lane(0, 1, 32'hB1B1B1B1, "mp_lane1");
      exp_lane(0, 2, 32'hC3C3C3C3, "mp_lane2");
      exp_lane(0, 3, 32'hD4D4D4D4, "mp_lane3");
      exp_lane(1, 0, 32'hA0A0A0A0, "mp_lane0");
      exp_lane(1, 1, 32'hB1B1B1B1, "mp_lane1");
      tick();

      // fill with index values, then clear_i with a simultaneous write
      for (int i = 0; i < 32; i++) wr(5'(i), 32'(i), 4'hF);
      set_rd(5'd9, 5'd10, 5'd0, 5'd31);
      exp_lane(0, 0, 32'd9, "fill_9");
      exp_lane(0, 3, 32'd31, "fill_31");
      tick();
      clr = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hFF; be = 4'hF;
      tick();
      clr = 1'b0; we = 1'b0;
      exp_busy(1'b1, "clear_accept");
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (i == 10) clr = 1'b1;
         if (i == 11) clr = 1'b0;
         exp_busy(i < 32, "clear_busy");
      end
      set_rd(5'd9, 5'd10, 5'd0, 5'd31);
      exp_lane(0, 0, 32'h0, "cleared_9");
      exp_lane(0, 1, 32'h0, "cleared_10");
      exp_lane(0, 3, 32'h0, "cleared_31");
      tick();

      // mid-sweep reset at ptr=17 restarts the sweep
      wr(5'd31, 32'h5A5A5A5A, 4'hF);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      repeat (17) tick();
      set_rd(5'd31, 5'd31, 5'd0, 5'd0);
      exp_lane(0, 0, 32'h0, "clear_masks_data");
      exp_lane(1, 0, 32'h0, "clear_masks_data");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_busy(1'b1, "midreset_busy");
      for (int i = 1; i <= 32; i++) begin
         tick();
         exp_busy(i < 32, "midreset_sweep");
      end
      exp_lane(0, 0, 32'h0, "midreset_cleared_31");
      tick();
      tick();

      if (sb_q.size() != 0) begin
         n_mis++;
         $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
